spi_master_arbiter: RTL
=======================

# spi_master_arbiter

Sequences and shares one `spi_master_driver` (mode 0, one byte per `start_i`) between `N_REQ` requesters. Each requester issues a multi-byte burst. The arbiter grants bursts round-robin and feeds bytes to the driver one at a time. It returns received bytes to the winner and drives one active-low slave select per requester, held low for the whole burst. Top level shares driver SCLK/MOSI/MISO across slaves and leaves the driver's own `spi_cs_o` unconnected.

## Interface
- `N_REQ`, 2, number of requesters/slaves (2..8)
- `LEN_W`, 4, burst length field width; burst = len+1 bytes (1..2^LEN_W)
- `WD_LIMIT`, 64, watchdog cycle limit (used only with `SPI_ARB_WATCHDOG_EN`)

Ports:
- `clk_i`  in  1  clock
- `rst_n_i`  in  1  reset; one clock; reset is synchronous and active-low
- `req_bi`  in  N_REQ  burst request per requester, level
- `len_bi`  in  N_REQ*LEN_W  per-requester byte count minus 1, slice k = requester k
- `tx_data_bi`  in  N_REQ*8  per-requester next TX byte
- `gnt_bo`  out  N_REQ  one-hot grant, held for the whole burst
- `tx_ack_bo`  out  N_REQ  1-cycle pulse: current TX byte consumed, present the next
- `rx_valid_o`  out  1  1-cycle pulse: `rx_data_bo` valid for the granted requester
- `rx_data_bo`  out  8  last received byte
- `done_bo`  out  N_REQ  1-cycle pulse at burst end
- `err_bo`  out  N_REQ  1-cycle pulse on watchdog abort (constant 0 without macro)
- `spi_cs_bo`  out  N_REQ  active-low slave selects
- `drv_start_o`  out  1  to driver `start_i`
- `drv_data_bo`  out  8  to driver `data_in_bi`
- `drv_busy_i`  in  1  from driver `busy_o`
- `drv_data_bi`  in  8  from driver `data_out_bo`

## Operation
- Reset values: `gnt_bo`=0, `spi_cs_bo`=all 1, `drv_start_o`=0, `drv_data_bo`=0, `tx_ack_bo`=0, `rx_valid_o`=0, `rx_data_bo`=0, `done_bo`=0, `err_bo`=0. Round-robin pointer=0, byte counter=0, state=S_IDLE.
- State machine:
  - **S_IDLE:** if `req_bi`≠0 and `drv_busy_i`=0, select the first set request searching upward from the pointer, wrapping modulo `N_REQ`. Register the winner into `gnt_bo` and `spi_cs_bo`, latch the winner's `len_bi` slice, clear the byte counter, go to S_START. Otherwise stay.
  - **S_START:** `drv_start_o`=1, `drv_data_bo`=winner's `tx_data_bi` slice, `tx_ack_bo[w]`=1, all for this one cycle. Go to S_WAIT_HI.
  - **S_WAIT_HI:** when `drv_busy_i`=1, go to S_WAIT_LO.
  - **S_WAIT_LO:** when `drv_busy_i`=0, register `drv_data_bi` into `rx_data_bo` and pulse `rx_valid_o`. If counter==latched len, go to S_DONE; else increment counter and go to S_START.
  - **S_DONE:** pulse `done_bo[w]`, clear `gnt_bo`, drive `spi_cs_bo` all 1, set pointer=(w+1) mod `N_REQ`, go to S_IDLE.
- Requests are sampled only in S_IDLE. Dropping `req_bi[w]` mid-burst is ignored; the burst completes at the latched length. Changes to `len_bi` mid-burst are ignored.
- `tx_data_bi` is sampled once per byte, in S_START.
- A requester holding `req_bi` high after `done_bo` re-competes. The pointer guarantees the others are served first.
- Reset mid-burst returns everything to reset values in one cycle. The driver may still be busy; S_IDLE's `drv_busy_i`=0 condition prevents a lost start.
- Unknown/illegal state encodings go to S_IDLE.

## Timing
- Request to first `drv_start_o`: 2 cycles (S_IDLE, then S_START).
- Driver holds busy for 33 cycles per byte.
- Byte period start-to-start: 35 cycles.
- Burst of L bytes: `gnt_bo` asserted for 35·L+1 cycles; `done_bo` pulses 2 cycles after the last busy fall.
- `rx_valid_o` pulses the cycle after the driver's busy falls.
- `spi_cs_bo[w]` goes low with `gnt_bo` and rises the cycle after S_DONE. It stays low across inter-byte gaps.
- Back-to-back bursts: at least 1 cycle of all-CS-high between them.

## Configuration
- `SPI_ARB_WATCHDOG_EN` defined: a cycle counter runs in S_WAIT_HI and S_WAIT_LO and clears on each state change.
  - Limits: 4 cycles in S_WAIT_HI, `WD_LIMIT` cycles in S_WAIT_LO.
  - On expiry: pulse `err_bo[w]` instead of `done_bo`, release grant and CS, advance the pointer, go to S_IDLE.
- Undefined: no counter; `err_bo` tied 0; the FSM waits indefinitely.

## Test plan
- Single requester: req0=1, len0=0, tx=0xA5, slave returns 0x3C → one `drv_start_o`; MOSI 0xA5 LSB-first; `rx_data_bo`=0x3C; `done_bo`=01; CS0 low for 36 cycles.
- Burst: req1, len1=2, tx 0x11/0x22/0x33 → three `tx_ack_bo[1]` pulses spaced 35 cycles; three `rx_valid_o` pulses; CS1 continuously low; `done_bo`=10.
- Contention: req=11 from reset, both len=0 → requester 0 served first, then 1. Repeat with both still requesting → order 0,1,0,1.
- Mid-burst request drop: req0 len=3, drop req0 after first byte → 4 bytes still transferred.
- Reset mid-burst: assert `rst_n_i`=0 in byte 2 for 1 cycle, driver still busy → all CS high next cycle; no `drv_start_o` until `drv_busy_i`=0.
- With `SPI_ARB_WATCHDOG_EN`: tie `drv_busy_i`=0 → `err_bo[w]` pulses 4 cycles after S_WAIT_HI entry; FSM returns to S_IDLE.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// Round-robin burst arbiter sharing one mode-0 SPI byte driver between N_REQ slaves.
// Optional watchdog abort of stuck transfers: define SPI_ARB_WATCHDOG_EN.
module spi_master_arbiter #(
  parameter int N_REQ    = 2,
  parameter int LEN_W    = 4,
  parameter int WD_LIMIT = 64
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [N_REQ-1:0]       req_bi,
  input  logic [N_REQ*LEN_W-1:0] len_bi,
  input  logic [N_REQ*8-1:0]     tx_data_bi,
  output logic [N_REQ-1:0]   gnt_bo,
  output logic [N_REQ-1:0]   tx_ack_bo,
  output logic               rx_valid_o,
  output logic [7:0]         rx_data_bo,
  output logic [N_REQ-1:0]   done_bo,
  output logic [N_REQ-1:0]   err_bo,
  output logic [N_REQ-1:0]   spi_cs_bo,
  output logic               drv_start_o,
  output logic [7:0]         drv_data_bo,
  input  logic               drv_busy_i,
  input  logic [7:0]         drv_data_bi
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8 || LEN_W < 1 || WD_LIMIT < 2)
  begin : g_bad_cfg
    $error("spi_master_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] w_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;

  logic [IDX_W-1:0] win;
  logic             win_vld;
  logic [IDX_W-1:0] sel;
  logic [7:0]       tx_sel;
  logic [LEN_W-1:0] len_sel;

`ifdef SPI_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1) + 1;
  logic [WD_W-1:0] wd_q;
`endif

  function automatic logic [N_REQ-1:0] onehot(
    input logic [IDX_W-1:0] i
  );
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [IDX_W-1:0] nxt(
    input logic [IDX_W-1:0] i
  );
    if (i == IDX_W'(N_REQ - 1))
      return '0;
    return i + 1'b1;
  endfunction

  // First set request at or above the pointer, wrapping.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] jx;
    win     = '0;
    win_vld = 1'b0;
    j       = 0;
    jx      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N_REQ)
        j = j - N_REQ;
      jx = IDX_W'(j);
      if (!win_vld && req_bi[jx]) begin
        win     = jx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel     = (state_q == S_IDLE) ? win : w_q;
    tx_sel  = '0;
    len_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (sel == IDX_W'(k)) begin
        tx_sel  = tx_data_bi[k*8 +: 8];
        len_sel = len_bi[k*LEN_W +: LEN_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      w_q         <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      gnt_bo      <= '0;
      spi_cs_bo   <= '1;
      tx_ack_bo   <= '0;
      rx_valid_o  <= 1'b0;
      rx_data_bo  <= '0;
      done_bo     <= '0;
      drv_start_o <= 1'b0;
      drv_data_bo <= '0;
`ifdef SPI_ARB_WATCHDOG_EN
      err_bo      <= '0;
      wd_q        <= '0;
`endif
    end else begin
      drv_start_o <= 1'b0;
      tx_ack_bo   <= '0;
      rx_valid_o  <= 1'b0;
      done_bo     <= '0;
`ifdef SPI_ARB_WATCHDOG_EN
      err_bo      <= '0;
      wd_q        <= '0;
`endif
      unique case (state_q)
        // Start pulse is issued on entry so it lines up with S_START.
        S_IDLE: begin
          if (win_vld && !drv_busy_i) begin
            w_q         <= win;
            gnt_bo      <= onehot(win);
            spi_cs_bo   <= ~onehot(win);
            len_q       <= len_sel;
            cnt_q       <= '0;
            drv_start_o <= 1'b1;
            drv_data_bo <= tx_sel;
            tx_ack_bo   <= onehot(win);
            state_q     <= S_START;
          end
        end
        S_START: begin
          state_q <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (drv_busy_i) begin
            state_q <= S_WAIT_LO;
          end
`ifdef SPI_ARB_WATCHDOG_EN
          else if (wd_q == WD_W'(3)) begin
            err_bo    <= onehot(w_q);
            gnt_bo    <= '0;
            spi_cs_bo <= '1;
            ptr_q     <= nxt(w_q);
            state_q   <= S_IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        S_WAIT_LO: begin
          if (!drv_busy_i) begin
            rx_data_bo <= drv_data_bi;
            rx_valid_o <= 1'b1;
            if (cnt_q == len_q) begin
              state_q <= S_DONE;
            end else begin
              cnt_q       <= cnt_q + 1'b1;
              drv_start_o <= 1'b1;
              drv_data_bo <= tx_sel;
              tx_ack_bo   <= onehot(w_q);
              state_q     <= S_START;
            end
          end
`ifdef SPI_ARB_WATCHDOG_EN
          else if (wd_q == WD_W'(WD_LIMIT - 1)) begin
            err_bo    <= onehot(w_q);
            gnt_bo    <= '0;
            spi_cs_bo <= '1;
            ptr_q     <= nxt(w_q);
            state_q   <= S_IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        S_DONE: begin
          done_bo   <= onehot(w_q);
          gnt_bo    <= '0;
          spi_cs_bo <= '1;
          ptr_q     <= nxt(w_q);
          state_q   <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifndef SPI_ARB_WATCHDOG_EN
  assign err_bo = '0;
`endif

endmodule
